// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/control inputs and display outputs of the scan driver.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;
  modport master (output value, dp, load, blank_lz, input seg, an, frame_start, pending);
  modport slave (input value, dp, load, blank_lz, output seg, an, frame_start, pending);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment driver with frame-aligned commit.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic system1000,
  input logic system1000_rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shadow_q, shadow_d, pend_q, pend_d;
  logic [3:0]    sdp_q, sdp_d, pdp_q, pdp_d;
  logic          pend_v_q, pend_v_d, wrap_q, wrap_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_start_q, frame_start_d, pending_q, pending_d;
  logic          slot_end, boundary, blank;
  logic [15:0]   upper;
  always_comb begin
    slot_end      = cnt_q == LAST;
    boundary      = slot_end && dig_q == 2'd3;
    cnt_d         = slot_end ? '0 : cnt_q + CW'(1);
    dig_d         = slot_end ? dig_q + 2'd1 : dig_q;
    pend_d        = bus.load ? bus.value : pend_q;
    pdp_d         = bus.load ? bus.dp : pdp_q;
    pend_v_d      = !boundary && (bus.load || pend_v_q);
    // a load landing on the boundary bypasses the pending register
    shadow_d      = boundary && bus.load ? bus.value : boundary && pend_v_q ? pend_q : shadow_q;
    sdp_d         = boundary && bus.load ? bus.dp : boundary && pend_v_q ? pdp_q : sdp_q;
    wrap_d        = boundary;
    upper         = shadow_q >> {dig_q, 2'b00};
    blank         = bus.blank_lz && dig_q != 2'd0 && upper == 16'h0;
    an_d          = 32'(cnt_q) < BLANK_CYCLES ? 4'hF : ~(4'b0001 << dig_q);
    seg_d         = {~sdp_q[dig_q], blank ? 7'h7F : SEG_LUT[upper[3:0]]};
    frame_start_d = wrap_q;
    pending_d     = pend_v_q;
  end
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      cnt_q         <= '0;
      dig_q         <= '0;
      shadow_q      <= '0;
      sdp_q         <= '0;
      pend_q        <= '0;
      pdp_q         <= '0;
      pend_v_q      <= 1'b0;
      wrap_q        <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 8'hFF;
      frame_start_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      shadow_q      <= shadow_d;
      sdp_q         <= sdp_d;
      pend_q        <= pend_d;
      pdp_q         <= pdp_d;
      pend_v_q      <= pend_v_d;
      wrap_q        <= wrap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
      pending_q     <= pending_d;
    end
  end
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;
endmodule
